// File: rtl/noc_req_arbiter.sv
// -----------------------------------------------------------------------------
// noc_req_arbiter
//
// Responder side of the FSM request handshake. Requests from N_FSM request
// FSMs are arbitrated round-robin. The winner goes into a single-entry NoC
// transmit slot and is marked outstanding. When the NoC completion carrying
// that requester's source ID returns, the requester gets a one-cycle ack.
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_fsm_req_*              packed per-requester request fields
//                            (requester i at bit offset i*W)
//   i_fsm_is_mem_req         1 = memory request, 0 = accelerator request
//   i_grant_inhibit          serializer owns this cycle; no grant allowed
//   o_arb_won                one-hot grant, combinational
//   o_ack                    registered one-cycle ack pulse per requester
//   o_noc_tx_valid/_*        transmit slot valid and buffered winner fields
//   i_noc_tx_ready           NoC takes the slot this cycle
//   i_noc_ack_valid/_src     NoC completion and its source ID
//   o_err_unmatched_ack      sticky: a completion matched no outstanding entry
// -----------------------------------------------------------------------------
module noc_req_arbiter #(
    parameter int N_FSM             = 4,
    parameter int ADDR_W            = 10,
    parameter int OPCODE_W          = 2,
    parameter int ADDR_W_ENCODING_W = 3,
    parameter int SRC_ID_W          = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic [N_FSM-1:0]                     i_fsm_req_valid,
    input  logic [N_FSM*ADDR_W-1:0]              i_fsm_req_addr,
    input  logic [N_FSM*ADDR_W_ENCODING_W-1:0]   i_fsm_req_width,
    input  logic [N_FSM*OPCODE_W-1:0]            i_fsm_req_opcode,
    input  logic [N_FSM*SRC_ID_W-1:0]            i_fsm_req_source_id,
    input  logic [N_FSM-1:0]                     i_fsm_is_mem_req,
    input  logic                                 i_grant_inhibit,
    output logic [N_FSM-1:0]                     o_arb_won,
    output logic [N_FSM-1:0]                     o_ack,
    output logic                                 o_noc_tx_valid,
    input  logic                                 i_noc_tx_ready,
    output logic [ADDR_W-1:0]                    o_noc_tx_addr,
    output logic [ADDR_W_ENCODING_W-1:0]         o_noc_tx_width,
    output logic [OPCODE_W-1:0]                  o_noc_tx_opcode,
    output logic [SRC_ID_W-1:0]                  o_noc_tx_source_id,
    output logic                                 o_noc_tx_is_mem,
    input  logic                                 i_noc_ack_valid,
    input  logic [SRC_ID_W-1:0]                  i_noc_ack_source_id,
    output logic                                 o_err_unmatched_ack
);

    localparam int RR_W = (N_FSM > 1) ? $clog2(N_FSM) : 1;

    // State
    logic [RR_W-1:0]              r_rr_ptr;
    logic [N_FSM-1:0]             r_outstanding;
    logic [SRC_ID_W-1:0]          r_held_src [N_FSM];
    logic                         r_tx_valid;
    logic [ADDR_W-1:0]            r_tx_addr;
    logic [ADDR_W_ENCODING_W-1:0] r_tx_width;
    logic [OPCODE_W-1:0]          r_tx_opcode;
    logic [SRC_ID_W-1:0]          r_tx_src;
    logic                         r_tx_is_mem;
    logic [N_FSM-1:0]             r_ack;
    logic                         r_err;

    // Combinational
    logic [N_FSM-1:0]             w_eligible;
    logic                         w_slot_free;
    logic                         w_grant;
    logic                         w_found_hi;
    logic                         w_found_lo;
    logic [RR_W-1:0]              w_idx_hi;
    logic [RR_W-1:0]              w_idx_lo;
    logic [RR_W-1:0]              w_win_idx;
    logic [RR_W-1:0]              w_rr_next;
    logic [N_FSM-1:0]             w_arb_won;
    logic [ADDR_W-1:0]            w_sel_addr;
    logic [ADDR_W_ENCODING_W-1:0] w_sel_width;
    logic [OPCODE_W-1:0]          w_sel_opcode;
    logic [SRC_ID_W-1:0]          w_sel_src;
    logic                         w_sel_is_mem;
    logic                         w_ack_hit;
    logic [N_FSM-1:0]             w_ack_onehot;

    // An outstanding requester is masked, which swallows the stale valid
    // cycle an FSM still drives right after being granted.
    assign w_eligible  = i_fsm_req_valid & ~r_outstanding;
    // The slot can take a new winner if empty or draining on this edge.
    assign w_slot_free = !r_tx_valid || i_noc_tx_ready;

    // Round-robin winner: first eligible index at or above r_rr_ptr,
    // otherwise the lowest eligible index (wrap-around).
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_idx_hi   = {RR_W{1'b0}};
        w_idx_lo   = {RR_W{1'b0}};
        for (int i = 0; i < N_FSM; i++) begin
            if (!w_found_hi && w_eligible[i] && (RR_W'(i) >= r_rr_ptr)) begin
                w_found_hi = 1'b1;
                w_idx_hi   = RR_W'(i);
            end else begin
                w_found_hi = w_found_hi;
            end
            if (!w_found_lo && w_eligible[i]) begin
                w_found_lo = 1'b1;
                w_idx_lo   = RR_W'(i);
            end else begin
                w_found_lo = w_found_lo;
            end
        end
        if (w_found_hi) begin
            w_win_idx = w_idx_hi;
        end else begin
            w_win_idx = w_idx_lo;
        end
    end

    assign w_grant = (|w_eligible) && !i_grant_inhibit && w_slot_free;

    // One-hot grant vector and the pointer value following the winner.
    always_comb begin
        w_arb_won = {N_FSM{1'b0}};
        for (int i = 0; i < N_FSM; i++) begin
            w_arb_won[i] = w_grant && (w_win_idx == RR_W'(i));
        end
        if (w_win_idx == RR_W'(N_FSM - 1)) begin
            w_rr_next = {RR_W{1'b0}};
        end else begin
            w_rr_next = w_win_idx + RR_W'(1);
        end
    end

    // Mux the winner's request fields toward the transmit slot.
    always_comb begin
        w_sel_addr   = {ADDR_W{1'b0}};
        w_sel_width  = {ADDR_W_ENCODING_W{1'b0}};
        w_sel_opcode = {OPCODE_W{1'b0}};
        w_sel_src    = {SRC_ID_W{1'b0}};
        w_sel_is_mem = 1'b0;
        for (int i = 0; i < N_FSM; i++) begin
            if (w_win_idx == RR_W'(i)) begin
                w_sel_addr   = i_fsm_req_addr[i*ADDR_W +: ADDR_W];
                w_sel_width  = i_fsm_req_width[i*ADDR_W_ENCODING_W +: ADDR_W_ENCODING_W];
                w_sel_opcode = i_fsm_req_opcode[i*OPCODE_W +: OPCODE_W];
                w_sel_src    = i_fsm_req_source_id[i*SRC_ID_W +: SRC_ID_W];
                w_sel_is_mem = i_fsm_is_mem_req[i];
            end else begin
                w_sel_is_mem = w_sel_is_mem;
            end
        end
    end

    // Completion match: lowest outstanding requester holding the source ID.
    always_comb begin
        w_ack_hit    = 1'b0;
        w_ack_onehot = {N_FSM{1'b0}};
        for (int i = 0; i < N_FSM; i++) begin
            if (!w_ack_hit && i_noc_ack_valid && r_outstanding[i] &&
                (r_held_src[i] == i_noc_ack_source_id)) begin
                w_ack_hit       = 1'b1;
                w_ack_onehot[i] = 1'b1;
            end else begin
                w_ack_hit = w_ack_hit;
            end
        end
    end

    // Transmit slot: load on grant, empty on drain without refill.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_valid  <= 1'b0;
            r_tx_addr   <= {ADDR_W{1'b0}};
            r_tx_width  <= {ADDR_W_ENCODING_W{1'b0}};
            r_tx_opcode <= {OPCODE_W{1'b0}};
            r_tx_src    <= {SRC_ID_W{1'b0}};
            r_tx_is_mem <= 1'b0;
        end else if (w_grant) begin
            r_tx_valid  <= 1'b1;
            r_tx_addr   <= w_sel_addr;
            r_tx_width  <= w_sel_width;
            r_tx_opcode <= w_sel_opcode;
            r_tx_src    <= w_sel_src;
            r_tx_is_mem <= w_sel_is_mem;
        end else if (r_tx_valid && i_noc_tx_ready) begin
            r_tx_valid  <= 1'b0;
        end else begin
            r_tx_valid  <= r_tx_valid;
        end
    end

    // Round-robin pointer advances past each winner.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= {RR_W{1'b0}};
        end else if (w_grant) begin
            r_rr_ptr <= w_rr_next;
        end else begin
            r_rr_ptr <= r_rr_ptr;
        end
    end

    // Outstanding tracking. A grant needs !outstanding and an ack needs
    // outstanding, so set and clear never hit the same requester together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_outstanding <= {N_FSM{1'b0}};
            for (int i = 0; i < N_FSM; i++) begin
                r_held_src[i] <= {SRC_ID_W{1'b0}};
            end
        end else begin
            r_outstanding <= (r_outstanding | w_arb_won) & ~w_ack_onehot;
            for (int i = 0; i < N_FSM; i++) begin
                if (w_arb_won[i]) begin
                    r_held_src[i] <= i_fsm_req_source_id[i*SRC_ID_W +: SRC_ID_W];
                end else begin
                    r_held_src[i] <= r_held_src[i];
                end
            end
        end
    end

    // Ack pulse and sticky unmatched-completion flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ack <= {N_FSM{1'b0}};
            r_err <= 1'b0;
        end else begin
            r_ack <= w_ack_onehot;
            if (i_noc_ack_valid && !w_ack_hit) begin
                r_err <= 1'b1;
            end else begin
                r_err <= r_err;
            end
        end
    end

    assign o_arb_won           = w_arb_won;
    assign o_ack               = r_ack;
    assign o_noc_tx_valid      = r_tx_valid;
    assign o_noc_tx_addr       = r_tx_addr;
    assign o_noc_tx_width      = r_tx_width;
    assign o_noc_tx_opcode     = r_tx_opcode;
    assign o_noc_tx_source_id  = r_tx_src;
    assign o_noc_tx_is_mem     = r_tx_is_mem;
    assign o_err_unmatched_ack = r_err;

endmodule

// File: doc/noc_req_arbiter.md
# noc_req_arbiter

Responder side of the FSM request handshake. Collects requests from `N_FSM` request FSMs, grants one per cycle window by round-robin (`arb_won`), buffers the winner into a single-entry NoC transmit slot, and returns a one-cycle `ack` to the originating FSM when the matching NoC response arrives. Sits between the per-request FSMs and the NoC injection port. Obeys the serializer inhibit so that a NoC grant never coincides with a serializer grant.

## Interface
Parameters:
- `N_FSM`, 4, number of requesting FSMs (2..8)
- `ADDR_W`, 10, request address width
- `OPCODE_W`, 2, request opcode width
- `ADDR_W_ENCODING_W`, 3, width-encoding field width
- `SRC_ID_W`, 4, source-ID width

Ports (`[i]` slices are packed, requester i at LSB-side offset i·W):
- Clocking: one clock; reset is asynchronous and active-low.
- `clk`, in, 1, clock
- `rst_n`, in, 1, async active-low reset
- `fsm_req_valid`, in, N_FSM, request valid per FSM
- `fsm_req_addr`, in, N_FSM·ADDR_W, request address
- `fsm_req_width`, in, N_FSM·ADDR_W_ENCODING_W, width encoding
- `fsm_req_opcode`, in, N_FSM·OPCODE_W, opcode
- `fsm_req_source_id`, in, N_FSM·SRC_ID_W, requester source ID
- `fsm_is_mem_req`, in, N_FSM, 1 = memory request, 0 = accelerator request
- `grant_inhibit`, in, 1, serializer arbiter busy this cycle; no grant allowed
- `arb_won`, out, N_FSM, one-hot grant, combinational, same cycle as sampled valid
- `ack`, out, N_FSM, registered one-cycle ack pulse per FSM
- `noc_tx_valid`, out, 1, transmit slot occupied
- `noc_tx_ready`, in, 1, NoC accepts slot this cycle
- `noc_tx_addr` / `noc_tx_width` / `noc_tx_opcode` / `noc_tx_source_id` / `noc_tx_is_mem`, out, field widths, buffered winner fields
- `noc_ack_valid`, in, 1, NoC completion response
- `noc_ack_source_id`, in, SRC_ID_W, source ID of the completion
- `err_unmatched_ack`, out, 1, sticky: ack with no matching outstanding requester

## Operation
- Per-requester state: `outstanding[i]` bit, `held_src[i]` (SRC_ID_W). Arbiter state: `rr_ptr` (clog2 N_FSM), tx slot.
- Eligible[i] = `fsm_req_valid[i]` & !`outstanding[i]`. Masking outstanding requesters absorbs the one stale valid cycle an FSM emits after its grant.
- Grant condition: any eligible & !`grant_inhibit` & (slot empty | (`noc_tx_valid` & `noc_tx_ready`)).
- Winner: first eligible index searching upward from `rr_ptr`, wrapping at N_FSM−1 → 0.
- On grant to i: `arb_won[i]`=1 that cycle; at edge, slot ← requester i fields, `noc_tx_valid`←1, `outstanding[i]`←1, `held_src[i]`←`fsm_req_source_id[i]`, `rr_ptr`←(i+1) mod N_FSM.
- Slot drains when `noc_tx_valid` & `noc_tx_ready`; `noc_tx_valid`←0 unless refilled same edge.
- Ack match: lowest i with `outstanding[i]` & `held_src[i]`==`noc_ack_source_id`. At edge, `ack[i]`←1 for one cycle, `outstanding[i]`←0. No match → `err_unmatched_ack`←1 (cleared only by reset); no ack emitted.
- Ack clearing `outstanding[i]` and a new request from i in the same cycle: i is ineligible that cycle, eligible next.
- A requester becoming eligible while granted slot is still pending transmit is legal; it will compete normally.

## Timing
- Reset values: `arb_won`=0, `ack`=0, `noc_tx_valid`=0, all `noc_tx_*` fields=0, `outstanding`=0, `held_src`=0, `rr_ptr`=0, `err_unmatched_ack`=0.
- Reset asserted mid-operation: all state cleared immediately; in-flight slot contents and outstanding acks are discarded.
- Grant → `noc_tx_valid`: 1 cycle. Back-to-back grants: one per cycle when `noc_tx_ready` held high.
- `noc_ack_valid` → `ack[i]`: 1 cycle, exactly one pulse per matched response.
- `arb_won` is never asserted while `grant_inhibit`=1; at most one bit set.
- Slot fields stable while `noc_tx_valid`=1 & !`noc_tx_ready`.

## Test plan
- Single request: FSM1 valid, addr=0x155, opcode=2, src=3, ready=1 → `arb_won`=4'b0010 same cycle, `noc_tx_valid` next cycle with addr 0x155, src 3; `noc_ack_valid` src=3 → `ack`=4'b0010 one cycle later, one cycle wide.
- Round-robin: FSM0..3 all valid continuously, acks returned immediately → grant order 0,1,2,3,0; `rr_ptr` wraps 3→0.
- Backpressure: `noc_tx_ready`=0 for 5 cycles with FSM0 and FSM2 valid → one grant (FSM0), slot fields stable, FSM2 granted the cycle ready rises.
- Inhibit: FSM1 valid, `grant_inhibit`=1 for 3 cycles → `arb_won`=0 throughout; grant cycle after inhibit drops.
- Stale valid: FSM0 holds valid 1 cycle past grant → no second grant, single `noc_tx_valid` beat.
- Unmatched ack: `noc_ack_valid` src=7 with no outstanding → `ack`=0, `err_unmatched_ack`=1 until `rst_n` low; async reset mid-transfer clears `noc_tx_valid` immediately.
